// File: rtl/gardner_ted_pkg.sv
// Shared definitions for the N-lane Gardner timing-error detector.
// Optional feature macro: GARDNER_TED_SAT_EN (saturating output word).
package gardner_ted_pkg;

  localparam int MaxChannels = 4;

  // Arming state: FILL until every lane's delay line holds one symbol of samples
  typedef enum logic {
    FILL,
    RUN
  } ted_state_t;

  // Output width that holds the accumulated error without loss
  function automatic int ted_out_width(input int il, input int nch, input int acc);
    return 2 * il + 1 + $clog2(nch) + $clog2(acc);
  endfunction

endpackage

// File: rtl/gardner_ted_lane.sv
// One Gardner lane: half/full-symbol delay line, difference and registered
// product. diff/mid are captured from the pre-shift taps on every accepted
// sample; the product follows one clock later.
module gardner_ted_lane
  import gardner_ted_pkg::*;
#(
  parameter int SamplesPerSymbol = 4,
  parameter int InputLengthBits  = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [InputLengthBits-1:0] sample,
  input  logic                           in_valid,
  output logic        [2*InputLengthBits:0] product
);

  localparam int IL  = InputLengthBits;
  localparam int SPS = SamplesPerSymbol;

  logic signed [IL-1:0] tap_reg [SPS];
  logic signed [IL:0]   diff_reg;
  logic signed [IL-1:0] mid_reg;
  logic signed [2*IL:0] product_reg;

  // Shift the delay line and capture x[n]-x[n-SPS] and x[n-SPS/2] before the shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SPS; i++) tap_reg[i] <= '0;
      diff_reg <= '0;
      mid_reg  <= '0;
    end else if (in_valid) begin
      diff_reg   <= (IL+1)'(sample) - (IL+1)'(tap_reg[SPS-1]);
      mid_reg    <= tap_reg[SPS/2-1];
      tap_reg[0] <= sample;
      for (int i = 1; i < SPS; i++) tap_reg[i] <= tap_reg[i-1];
    end
  end

  // Stage-1 product register; full precision, no rounding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_reg <= '0;
    end else begin
      product_reg <= (2*IL+1)'(diff_reg) * (2*IL+1)'(mid_reg);
    end
  end

  assign product = product_reg;

endmodule

// File: rtl/gardner_ted_nch.sv
// N-lane Gardner timing-error detector with symbol accumulation and a
// ready/valid output. Optional feature macro: GARDNER_TED_SAT_EN, which lifts
// the output width requirement and saturates each loaded word instead.
module gardner_ted_nch
  import gardner_ted_pkg::*;
#(
  parameter int NumChannels      = 2,
  parameter int SamplesPerSymbol = 4,
  parameter int InputLengthBits  = 12,
  parameter int AccumSymbols     = 1,
  parameter int OutputLengthBits = 26
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NumChannels*InputLengthBits-1:0] in,
  input  logic                                    in_valid,
  input  logic                                    trigger,
  output logic [OutputLengthBits-1:0]             out,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    overrun
);

  localparam int IL = InputLengthBits;
  localparam int PW = 2 * IL + 1;                      // per-lane product
  localparam int SW = PW + $clog2(NumChannels);        // lane sum
  localparam int AW = SW + $clog2(AccumSymbols);       // accumulator
  localparam int OW = OutputLengthBits;
  localparam int XW = (OW > AW) ? OW : AW;             // common width for output formatting
  localparam int CW = $clog2(AccumSymbols + 1);
  localparam int FW = $clog2(SamplesPerSymbol + 1);

  // Elaboration-time parameter checks
  if ((SamplesPerSymbol % 2) != 0 || SamplesPerSymbol < 2) begin : g_bad_sps
    $error("gardner_ted_nch: SamplesPerSymbol must be even and >= 2");
  end
  if (NumChannels < 1 || NumChannels > MaxChannels) begin : g_bad_nch
    $error("gardner_ted_nch: NumChannels must be 1..4");
  end
  if (AccumSymbols < 1 || AccumSymbols > 256) begin : g_bad_acc
    $error("gardner_ted_nch: AccumSymbols must be 1..256");
  end
`ifndef GARDNER_TED_SAT_EN
  if (OW < ted_out_width(IL, NumChannels, AccumSymbols)) begin : g_bad_ow
    $error("gardner_ted_nch: OutputLengthBits too narrow for lossless accumulation");
  end
`endif

  logic [NumChannels-1:0][PW-1:0] lane_product;

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_lane
    gardner_ted_lane #(
      .SamplesPerSymbol(SamplesPerSymbol),
      .InputLengthBits (InputLengthBits)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .sample  (in[gi*IL +: IL]),
      .in_valid(in_valid),
      .product (lane_product[gi])
    );
  end

  ted_state_t           state_reg, state_next;
  logic [FW-1:0]        fill_cnt_reg, fill_cnt_next;
  logic                 fire;
  logic                 fire_s1_reg, fire_s2_reg;
  logic signed [AW-1:0] acc_reg;
  logic [CW-1:0]        sym_cnt_reg;
  logic [OW-1:0]        out_reg;
  logic                 out_valid_reg, overrun_reg;
  logic signed [SW-1:0] lane_sum;
  logic signed [AW-1:0] sum_next;
  logic signed [XW-1:0] sum_ext;
  logic [OW-1:0]        word;
  logic                 word_done;

  // Fill counter and arming state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FILL;
      fill_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
    end
  end

  // Arm once a full symbol of samples is buffered; fire only on valid on-time samples
  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    fire          = 1'b0;
    case (state_reg)
      FILL: begin
        if (in_valid) begin
          fill_cnt_next = fill_cnt_reg + FW'(1);
          if (fill_cnt_reg == FW'(SamplesPerSymbol - 1)) state_next = RUN;
        end
      end
      RUN: begin
        fire = in_valid && trigger;
      end
      default: state_next = FILL;
    endcase
  end

  // Sum the lanes, add to the running accumulator and format the output word
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < NumChannels; k++) lane_sum += SW'(signed'(lane_product[k]));
    sum_next  = acc_reg + AW'(lane_sum);
    word_done = fire_s2_reg && (sym_cnt_reg == CW'(AccumSymbols - 1));
    sum_ext   = XW'(sum_next);
    word      = sum_ext[OW-1:0];
`ifdef GARDNER_TED_SAT_EN
    if (!((&sum_ext[XW-1:OW-1]) || !(|sum_ext[XW-1:OW-1])))
      word = sum_ext[XW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
`endif
  end

  // Fire pipeline, accumulator and symbol counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_s1_reg <= 1'b0;
      fire_s2_reg <= 1'b0;
      acc_reg     <= '0;
      sym_cnt_reg <= '0;
    end else begin
      fire_s1_reg <= fire;
      fire_s2_reg <= fire_s1_reg;
      if (fire_s2_reg) begin
        if (word_done) begin
          acc_reg     <= '0;
          sym_cnt_reg <= '0;
        end else begin
          acc_reg     <= sum_next;
          sym_cnt_reg <= sym_cnt_reg + CW'(1);
        end
      end
    end
  end

  // Output register with ready/valid handshake; a word arriving while blocked is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (word_done && (!out_valid_reg || out_ready)) begin
        out_reg       <= word;
        out_valid_reg <= 1'b1;
      end else begin
        if (word_done) overrun_reg <= 1'b1;
        if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
      end
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign overrun   = overrun_reg;

endmodule
